if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_unit
//  Description : Instruction-fetch stage of the five-stage MIPS pipeline.
//                Issues single-outstanding requests to the instruction SRAM
//                over a req/addr_ok/data_ok handshake, buffers one returned
//                instruction and redirects fetch after the branch delay slot.
//  Revision    : 1.0  initial release
// ============================================================================
module if_fetch_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic [32:0] br_bus,
   output logic        inst_sram_req,
   output logic [31:0] inst_sram_addr,
   input  logic        inst_sram_addr_ok,
   input  logic        inst_sram_data_ok,
   input  logic [31:0] inst_sram_rdata,
   output logic [64:0] if_to_id_bus
);

   localparam logic [31:0] C_RESET_PC = 32'hBFC0_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [31:0] r_fetch_pc;
   logic        r_seq_cnt;
   logic        r_buf_v;
   logic [31:0] r_buf_pc;
   logic [31:0] r_buf_inst;
   logic        r_redir_v;
   logic [31:0] r_redir_target;
   logic [31:0] r_inflight_pc;
   logic [31:0] r_req_addr;

   logic        w_br_e;
   logic [31:0] w_br_addr;
   logic        w_br_acc;
   logic        w_data_in;
   logic        w_consume;
   logic        w_slot_free;
   logic [31:0] w_new_addr;
   logic        w_issue;
   logic        w_fire;
   logic        w_unused_stall;

   assign w_br_e         = br_bus[32];
   assign w_br_addr      = br_bus[31:0];
   // A held br_e only counts once: on the cycle ID's instruction advances.
   assign w_br_acc       = w_br_e & ~stall[2];
   assign w_data_in      = (r_state == S_WAIT) & inst_sram_data_ok;
   assign w_unused_stall = ^stall[5:3];

   // Deliver the buffered instruction first, else bypass returning data.
   always_comb begin
      if_to_id_bus = '0;
      if (r_buf_v) begin
         if_to_id_bus = {1'b1, r_buf_pc, r_buf_inst};
      end else if (w_data_in) begin
         if_to_id_bus = {1'b1, r_inflight_pc, inst_sram_rdata};
      end
   end

   assign w_consume   = if_to_id_bus[64] & ~stall[1];
   // Room for a new request: nothing ahead of ID, or it leaves this cycle.
   assign w_slot_free = ~r_seq_cnt | w_consume;
   // With the delay slot already accepted, a taken branch steers this request.
   assign w_new_addr  = (w_br_acc & r_seq_cnt) ? w_br_addr : r_fetch_pc;
   assign w_fire      = inst_sram_req & inst_sram_addr_ok;

   // Next-state and request generation; REQ holds address until accepted.
   always_comb begin
      w_state_nxt    = r_state;
      w_issue        = 1'b0;
      inst_sram_req  = 1'b0;
      inst_sram_addr = w_new_addr;
      case (r_state)
         S_REQ: begin
            inst_sram_req  = 1'b1;
            inst_sram_addr = r_req_addr;
            if (inst_sram_addr_ok) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_IDLE, S_WAIT: begin
            // WAIT may launch the next request in the cycle its data returns.
            if ((r_state == S_IDLE) || inst_sram_data_ok) begin
               w_issue       = ~rst & ~stall[0] & w_slot_free;
               inst_sram_req = w_issue;
               if (w_issue) begin
                  w_state_nxt = inst_sram_addr_ok ? S_WAIT : S_REQ;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state, held request address, in-flight pc and ahead-of-ID count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_req_addr    <= C_RESET_PC;
         r_inflight_pc <= C_RESET_PC;
         r_seq_cnt     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue) begin
            r_req_addr <= inst_sram_addr;
         end
         if (w_fire) begin
            r_inflight_pc <= inst_sram_addr;
         end
         case ({w_fire, w_consume})
            2'b10:   r_seq_cnt <= 1'b1;
            2'b01:   r_seq_cnt <= 1'b0;
            default: r_seq_cnt <= r_seq_cnt;
         endcase
      end
   end

   // One-entry buffer captures returning data that ID did not take.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf_v    <= 1'b0;
         r_buf_pc   <= '0;
         r_buf_inst <= '0;
      end else begin
         if (w_consume) begin
            r_buf_v <= 1'b0;
         end
         if (w_data_in & ~w_consume) begin
            r_buf_v    <= 1'b1;
            r_buf_pc   <= r_inflight_pc;
            r_buf_inst <= inst_sram_rdata;
         end
      end
   end

   // Next fetch address and deferred redirect once the delay slot is issued.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc     <= C_RESET_PC;
         r_redir_v      <= 1'b0;
         r_redir_target <= '0;
      end else begin
         if (w_fire) begin
            if (r_redir_v) begin
               r_fetch_pc <= r_redir_target;
               r_redir_v  <= 1'b0;
            end else begin
               r_fetch_pc <= inst_sram_addr + 32'd4;
            end
         end
         if (w_br_acc) begin
            if (r_seq_cnt) begin
               r_fetch_pc <= w_fire ? (w_br_addr + 32'd4) : w_br_addr;
            end else if (w_fire) begin
               // The request accepted now is the delay slot itself.
               r_fetch_pc <= w_br_addr;
            end else begin
               r_redir_v      <= 1'b1;
               r_redir_target <= w_br_addr;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_unit
//  Description : Directed bench for if_fetch_unit with a small SRAM model
//                (programmable addr_ok delay and data latency).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic [32:0] br_bus;
   logic        inst_sram_req;
   logic [31:0] inst_sram_addr;
   logic        inst_sram_addr_ok;
   logic        inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic [64:0] if_to_id_bus;

   int n_tests = 0;
   int n_fail  = 0;

   // SRAM model state
   int          lat;
   int          aok_delay;
   int          req_wait;
   int          pend_cnt;
   logic        pend_v;
   logic [31:0] pend_addr;
   logic        aok_block;

   logic [31:0] fired[$];
   logic [31:0] got[$];
   logic [31:0] exp_f[$];
   logic [31:0] exp_g[$];

   logic        s_req;
   logic [31:0] s_addr;
   logic [64:0] s_bus;

   localparam logic [31:0] PC0 = 32'hBFC0_0000;
   localparam logic [32:0] BR_100 = {1'b1, 32'hBFC0_0100};

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .br_bus            (br_bus),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .if_to_id_bus      (if_to_id_bus)
   );

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_F00F;
   endfunction

   task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive SRAM inputs, sample at negedge, advance model.
   task automatic cycle();
      inst_sram_data_ok = pend_v && (pend_cnt == 0);
      inst_sram_rdata   = inst_sram_data_ok ? inst_of(pend_addr) : 32'h0;
      inst_sram_addr_ok = !aok_block && (req_wait >= aok_delay);
      @(negedge clk);
      s_req  = inst_sram_req;
      s_addr = inst_sram_addr;
      s_bus  = if_to_id_bus;
      if (s_req && inst_sram_addr_ok) fired.push_back(s_addr);
      if (s_bus[64] && !stall[1]) begin
         got.push_back(s_bus[63:32]);
         check("inst", 65'(s_bus[31:0]), 65'(inst_of(s_bus[63:32])));
      end
      @(posedge clk);
      if (inst_sram_data_ok) pend_v = 1'b0;
      else if (pend_v) pend_cnt--;
      if (s_req && inst_sram_addr_ok) begin
         pend_v    = 1'b1;
         pend_addr = s_addr;
         pend_cnt  = lat - 1;
         req_wait  = 0;
      end else if (s_req) begin
         req_wait++;
      end else begin
         req_wait = 0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst               = 1'b1;
      stall             = 6'd0;
      br_bus            = 33'd0;
      inst_sram_addr_ok = 1'b0;
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata   = 32'h0;
      pend_v            = 1'b0;
      pend_cnt          = 0;
      pend_addr         = 32'h0;
      req_wait          = 0;
      aok_block         = 1'b0;
      lat               = 1;
      aok_delay         = 0;
      fired.delete();
      got.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_lists(input string tag);
      check({tag, "_nfire"}, 65'(fired.size()), 65'(exp_f.size()));
      for (int i = 0; i < exp_f.size() && i < fired.size(); i++)
         check($sformatf("%s_fire%0d", tag, i), 65'(fired[i]), 65'(exp_f[i]));
      check({tag, "_ngot"}, 65'(got.size()), 65'(exp_g.size()));
      for (int i = 0; i < exp_g.size() && i < got.size(); i++)
         check($sformatf("%s_got%0d", tag, i), 65'(got[i]), 65'(exp_g[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [10:0] e2_req;
      logic [10:0] e2_ce;
      logic [5:0]  e5_req;
      logic [31:0] a;

      // ---------------- reset state ----------------
      rst = 1'b1; stall = 6'd0; br_bus = 33'd0;
      inst_sram_addr_ok = 1'b1; inst_sram_data_ok = 1'b0; inst_sram_rdata = 32'h0;
      @(negedge clk);
      check("rst_req", 65'(inst_sram_req), 65'd0);
      check("rst_bus", if_to_id_bus, 65'd0);

      // ---------------- ideal SRAM streaming ----------------
      do_reset();
      for (int k = 0; k < 6; k++) begin
         cycle();
         check("t1_req", 65'(s_req), 65'd1);
         check("t1_addr", 65'(s_addr), 65'(PC0 + 32'(4 * k)));
         check("t1_ce", 65'(s_bus[64]), 65'(k >= 1));
         if (k >= 1) check("t1_pc", 65'(s_bus[63:32]), 65'(PC0 + 32'(4 * (k - 1))));
      end

      // ---------------- slow SRAM ----------------
      do_reset();
      aok_delay = 2; lat = 3;
      e2_req = 11'b10011100111;
      e2_ce  = 11'b10000100000;
      for (int k = 0; k < 11; k++) begin
         cycle();
         check("t2_req", 65'(s_req), 65'(e2_req[k]));
         check("t2_ce", 65'(s_bus[64]), 65'(e2_ce[k]));
         a = (k <= 2) ? PC0 : (k <= 7) ? (PC0 + 32'd4) : (PC0 + 32'd8);
         if (s_req) check("t2_addr", 65'(s_addr), 65'(a));
      end
      exp_f = '{32'hBFC0_0000, 32'hBFC0_0004};
      exp_g = '{32'hBFC0_0000, 32'hBFC0_0004};
      check_lists("t2");

      // ---------------- branch, delay slot in flight ----------------
      do_reset();
      for (int k = 0; k < 7; k++) begin
         br_bus = (k == 3) ? BR_100 : 33'd0;
         cycle();
      end
      br_bus = 33'd0;
      exp_f = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100,
                32'hBFC0_0104, 32'hBFC0_0108, 32'hBFC0_010C};
      exp_g = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100,
                32'hBFC0_0104, 32'hBFC0_0108};
      check_lists("t3");

      // ---------------- branch, delay slot not yet accepted ----------------
      do_reset();
      for (int k = 0; k < 8; k++) begin
         aok_block = (k >= 2 && k <= 4);
         br_bus    = (k == 3) ? BR_100 : 33'd0;
         cycle();
         if (k == 3 || k == 4) begin
            check("t4_hold_req", 65'(s_req), 65'd1);
            check("t4_hold_addr", 65'(s_addr), 65'(32'hBFC0_0008));
         end
      end
      aok_block = 1'b0; br_bus = 33'd0;
      exp_f = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100, 32'hBFC0_0104};
      exp_g = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100};
      check_lists("t4");

      // ---------------- ID stall while data returns ----------------
      do_reset();
      e5_req = 6'b110001;
      for (int k = 0; k < 6; k++) begin
         stall = (k >= 1 && k <= 3) ? 6'b000011 : 6'd0;
         cycle();
         check("t5_req", 65'(s_req), 65'(e5_req[k]));
         if (k >= 1 && k <= 3)
            check("t5_bus", s_bus, {1'b1, PC0, inst_of(PC0)});
      end
      stall = 6'd0;
      exp_f = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008};
      exp_g = '{32'hBFC0_0000, 32'hBFC0_0004};
      check_lists("t5");

      // ---------------- branch held under ID stall ----------------
      do_reset();
      for (int k = 0; k < 9; k++) begin
         stall  = (k >= 3 && k <= 5) ? 6'b000110 : 6'd0;
         br_bus = (k >= 3 && k <= 6) ? BR_100 : 33'd0;
         cycle();
         if (k >= 3 && k <= 5) begin
            check("t6_req", 65'(s_req), 65'd0);
            check("t6_bus", s_bus, {1'b1, 32'hBFC0_0008, inst_of(32'hBFC0_0008)});
         end
      end
      stall = 6'd0; br_bus = 33'd0;
      exp_f = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100,
                32'hBFC0_0104, 32'hBFC0_0108};
      exp_g = '{32'hBFC0_0000, 32'hBFC0_0004, 32'hBFC0_0008, 32'hBFC0_0100,
                32'hBFC0_0104};
      check_lists("t6");

      // ---------------- asynchronous reset while in WAIT ----------------
      do_reset();
      lat = 3;
      repeat (3) cycle();
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata   = inst_of(PC0);
      inst_sram_addr_ok = 1'b1;
      #2;
      check("t7_pre_req", 65'(inst_sram_req), 65'd1);
      check("t7_pre_ce", 65'(if_to_id_bus[64]), 65'd1);
      rst = 1'b1;
      #1;
      check("t7_rst_req", 65'(inst_sram_req), 65'd0);
      check("t7_rst_bus", if_to_id_bus, 65'd0);
      inst_sram_data_ok = 1'b0;
      pend_v = 1'b0; req_wait = 0; lat = 1;
      fired.delete(); got.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      cycle();
      check("t7_first_req", 65'(s_req), 65'd1);
      check("t7_first_addr", 65'(s_addr), 65'(PC0));
      cycle();
      check("t7_first_bus", s_bus, {1'b1, PC0, inst_of(PC0)});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
